vga_frame_controller: RTL and testbench

- Sequences the VGA rendering datapath: generates the 640x480@60 Hz raster counters that drive the background/sprite renderers and the top-level pixel mux.
- Aligns hsync/vsync/blank with the renderers' registered pixel pipeline.
- Snapshots game-side state once per frame, at vblank start, so every renderer sees a tear-free, frame-consistent copy.

---
 rtl/vga_frame_controller.sv | 149 ++++++++++++++
 tb/tb_vga_frame_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_controller.sv
// ---------------------------------------------------------------------------
// vga_frame_controller
// Raster timing and per-frame state snapshot for the VGA rendering datapath.
// Generates the horizontal/vertical counters that drive the renderers.
// Delays hsync/vsync/blank to line up with the renderers' registered pixel
// pipeline. Latches the game-state bus once per frame at vblank start, so
// every renderer sees a tear-free copy for the whole frame.
//
// Ports:
//   vga_clk     in   pixel clock
//   rst         in   synchronous active-high reset
//   snap_in     in   live game state, packed, SNAP_W bits
//   x, y        out  current raster counters (10 bits, registered)
//   video_on    out  counters inside visible area (combinational, undelayed)
//   hsync       out  active-low hsync, PIPE_DELAY cycles late
//   vsync       out  active-low vsync, PIPE_DELAY cycles late
//   blank       out  active-high blank, PIPE_DELAY cycles late
//   frame_start out  one-cycle pulse at h=0, v=V_ACTIVE (combinational)
//   snap_out    out  frame-stable copy of snap_in
//   snap_valid  out  one-cycle pulse the cycle snap_out is updated
//   frame_cnt   out  frames completed, wraps modulo 256
// ---------------------------------------------------------------------------
module vga_frame_controller #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned PIPE_DELAY = 2,
    parameter int unsigned SNAP_W     = 64
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic [SNAP_W-1:0] snap_in,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic              video_on,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              frame_start,
    output logic [SNAP_W-1:0] snap_out,
    output logic              snap_valid,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;
    // Keep the delay vectors legal when PIPE_DELAY is 0; they are unused then.
    localparam int unsigned PD_W    = (PIPE_DELAY == 0) ? 1 : PIPE_DELAY;

    logic [CNT_W-1:0]  r_h;
    logic [CNT_W-1:0]  r_v;
    logic              w_video_on;
    logic              w_frame_start;
    logic              w_hsync_raw;
    logic              w_vsync_raw;
    logic              w_blank_raw;
    logic [PD_W-1:0]   r_hs_pipe;
    logic [PD_W-1:0]   r_vs_pipe;
    logic [PD_W-1:0]   r_bl_pipe;
    logic [SNAP_W-1:0] r_snap;
    logic              r_snap_valid;
    logic [7:0]        r_frame_cnt;

    // Raster counters: v advances only when h wraps.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == CNT_W'(H_TOTAL - 1)) begin
            r_h <= '0;
            r_v <= (r_v == CNT_W'(V_TOTAL - 1)) ? '0 : r_v + CNT_W'(1);
        end else begin
            r_h <= r_h + CNT_W'(1);
        end
    end

    // Raw timing decodes from the current counter values.
    always_comb begin
        w_video_on    = (r_h < CNT_W'(H_ACTIVE)) && (r_v < CNT_W'(V_ACTIVE));
        w_frame_start = (r_h == '0) && (r_v == CNT_W'(V_ACTIVE));
        w_hsync_raw   = !((r_h >= CNT_W'(HS_BEG)) && (r_h < CNT_W'(HS_END)));
        w_vsync_raw   = !((r_v >= CNT_W'(VS_BEG)) && (r_v < CNT_W'(VS_END)));
        w_blank_raw   = !w_video_on;
    end

    // Delay chains; stage 0 takes the raw value, last stage drives the port.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_hs_pipe <= '1;
            r_vs_pipe <= '1;
            r_bl_pipe <= '1;
        end else begin
            r_hs_pipe[0] <= w_hsync_raw;
            r_vs_pipe[0] <= w_vsync_raw;
            r_bl_pipe[0] <= w_blank_raw;
            for (int i = 1; i < int'(PD_W); i++) begin
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
                r_bl_pipe[i] <= r_bl_pipe[i-1];
            end
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hsync = w_hsync_raw;
            assign vsync = w_vsync_raw;
            assign blank = w_blank_raw;
        end else begin : g_delay
            assign hsync = r_hs_pipe[PD_W-1];
            assign vsync = r_vs_pipe[PD_W-1];
            assign blank = r_bl_pipe[PD_W-1];
        end
    endgenerate

    // Frame snapshot: capture only on the vblank-start edge; reset wins.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_snap_valid <= w_frame_start;
            if (w_frame_start) begin
                r_snap      <= snap_in;
                r_frame_cnt <= r_frame_cnt + 8'(1);
            end
        end
    end

    assign x           = r_h;
    assign y           = r_v;
    assign video_on    = w_video_on;
    assign frame_start = w_frame_start;
    assign snap_out    = r_snap;
    assign snap_valid  = r_snap_valid;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_frame_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_controller
// Self-checking bench for vga_frame_controller using shrunk raster timing
// (15 x 8 totals) so that hundreds of frames fit in a short run.
// A predictor tracks the raster and pushes each expected capture into a
// scoreboard queue; a monitor pops it whenever snap_valid pulses.
// ---------------------------------------------------------------------------
module tb_vga_frame_controller;

    localparam int unsigned HA = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 2;
    localparam int unsigned VA = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned PD = 2;
    localparam int unsigned SW = 64;
    localparam int unsigned HT = HA + HF + HS + HB;   // 15
    localparam int unsigned VT = VA + VF + VS + VB;   // 8

    logic          clk;
    logic          rst;
    logic [SW-1:0] snap_in;
    logic [9:0]    x;
    logic [9:0]    y;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic          frame_start;
    logic [SW-1:0] snap_out;
    logic          snap_valid;
    logic [7:0]    frame_cnt;

    vga_frame_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_DELAY(PD), .SNAP_W(SW)
    ) dut (
        .vga_clk    (clk),
        .rst        (rst),
        .snap_in    (snap_in),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank      (blank),
        .frame_start(frame_start),
        .snap_out   (snap_out),
        .snap_valid (snap_valid),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [SW-1:0] snap;
        logic [7:0]    cnt;
    } sb_t;

    sb_t sb_q[$];

    // Reference raster model, state as it should be after the last edge.
    int            mh = 0;
    int            mv = 0;
    logic [PD-1:0] mhs = '1;
    logic [PD-1:0] mvs = '1;
    logic [PD-1:0] mbl = '1;
    logic [SW-1:0] msnap = '0;
    logic [7:0]    mcnt = '0;
    logic          msv = 1'b0;

    // Predictor: compare present outputs, then advance with current inputs.
    always @(negedge clk) begin
        logic fs, hs_r, vs_r, bl_r;
        chk("x",           64'(x),           64'(mh));
        chk("y",           64'(y),           64'(mv));
        chk("video_on",    64'(video_on),    64'((mh < int'(HA)) && (mv < int'(VA))));
        chk("frame_start", 64'(frame_start), 64'((mh == 0) && (mv == int'(VA))));
        chk("hsync",       64'(hsync),       64'(mhs[PD-1]));
        chk("vsync",       64'(vsync),       64'(mvs[PD-1]));
        chk("blank",       64'(blank),       64'(mbl[PD-1]));
        chk("snap_out",    64'(snap_out),    64'(msnap));
        chk("snap_valid",  64'(snap_valid),  64'(msv));
        chk("frame_cnt",   64'(frame_cnt),   64'(mcnt));
        if (rst) begin
            mh = 0; mv = 0;
            mhs = '1; mvs = '1; mbl = '1;
            msnap = '0; mcnt = '0; msv = 1'b0;
        end else begin
            fs   = (mh == 0) && (mv == int'(VA));
            hs_r = !((mh >= int'(HA + HF)) && (mh < int'(HA + HF + HS)));
            vs_r = !((mv >= int'(VA + VF)) && (mv < int'(VA + VF + VS)));
            bl_r = !((mh < int'(HA)) && (mv < int'(VA)));
            mhs  = {mhs[PD-2:0], hs_r};
            mvs  = {mvs[PD-2:0], vs_r};
            mbl  = {mbl[PD-2:0], bl_r};
            msv  = fs;
            if (fs) begin
                msnap = snap_in;
                mcnt  = mcnt + 8'd1;
                sb_q.push_back({snap_in, mcnt});
            end
            mh++;
            if (mh == int'(HT)) begin
                mh = 0;
                mv++;
                if (mv == int'(VT)) mv = 0;
            end
        end
    end

    // Scoreboard monitor: consume one expected capture per snap_valid pulse.
    logic [7:0] last_cnt  = '0;
    bit         have_last = 1'b0;
    bit         wrap_seen = 1'b0;

    always @(negedge clk) begin
        sb_t e;
        if (snap_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_capture", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("sb_snap_out",  64'(snap_out),  64'(e.snap));
                chk("sb_frame_cnt", 64'(frame_cnt), 64'(e.cnt));
                if (have_last && last_cnt == 8'hff) begin
                    chk("frame_cnt_wrap", 64'(frame_cnt), 64'(0));
                    wrap_seen = 1'b1;
                end
                last_cnt  = frame_cnt;
                have_last = 1'b1;
            end
        end
    end

    // Directed timing measurements on the delayed outputs.
    int   cyc = 0;
    int   hs_run = 0;
    int   vs_run = 0;
    int   last_fs = -1;
    logic prev_hs = 1'b1;
    logic prev_bl = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hs_run = 0; vs_run = 0; last_fs = -1;
            prev_hs = 1'b1; prev_bl = 1'b1;
        end else begin
            if (hsync === 1'b0) hs_run++;
            else if (hs_run > 0) begin
                chk("hsync_width", 64'(hs_run), 64'(HS));
                hs_run = 0;
            end
            if (vsync === 1'b0) vs_run++;
            else if (vs_run > 0) begin
                chk("vsync_width", 64'(vs_run), 64'(VS * HT));
                vs_run = 0;
            end
            if (prev_hs === 1'b1 && hsync === 1'b0)
                chk("hsync_fall_x", 64'(x), 64'(HA + HF + PD));
            if (prev_bl === 1'b0 && blank === 1'b1)
                chk("blank_rise_x", 64'(x), 64'(HA + PD));
            if (prev_bl === 1'b1 && blank === 1'b0)
                chk("blank_fall_x", 64'(x), 64'(PD));
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) chk("frame_period", 64'(cyc - last_fs), 64'(HT * VT));
                last_fs = cyc;
            end
            prev_hs = hsync;
            prev_bl = blank;
        end
    end

    // Incrementing game state, a new value every cycle.
    initial begin
        snap_in = 64'h0123_4567_0000_0000;
        forever begin
            step();
            snap_in = snap_in + 64'h0000_0001_0000_0003;
        end
    end

    // Main stimulus sequence.
    initial begin
        bit found;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (50) step();
        // Mid-count reset held for 3 cycles.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (3 * HT * VT) step();

        // Reset landing exactly on the capture edge.
        rst = 1'b1;
        step();
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < int'(2 * HT * VT) && !found; i++) begin
            if (frame_start === 1'b1) found = 1'b1;
            else step();
        end
        if (!found) chk("collision_frame_start_timeout", 64'(0), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("collision_snap_out",  64'(snap_out),  64'(0));
        chk("collision_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("collision_x",         64'(x),         64'(1));
        chk("collision_y",         64'(y),         64'(0));

        // Enough frames for frame_cnt to wrap past 255.
        repeat (257 * HT * VT + 10) step();

        chk("wrap_seen",  64'(wrap_seen),   64'(1));
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
